// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor
//   Majority voter and health monitor for the three replica outputs of a
//   triplicated state machine. Every cycle the three replica bits are voted,
//   the disagreeing replica (if any) is identified, a saturating mismatch
//   count is kept per replica, and a per-replica persistence FSM separates
//   single-cycle upsets from a replica that keeps disagreeing.
//
// Parameters
//   CNT_W    width of each mismatch counter (saturates at all-ones)
//   PERSIST  consecutive mismatch cycles that declare a replica faulty (1..255)
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset (priority over clr and data)
//   inA/B/C   replica bits
//   clr       synchronous clear of counters, run lengths, FSMs and fault flags
//   out       registered majority vote
//   err       registered: a replica disagreed in the sampled cycle
//   errIdx    registered: 0 none, 1 A, 2 B, 3 C
//   cntA/B/C  saturating mismatch counters
//   fault     sticky persistent-fault flags {C,B,A}
//   faultAny  OR of the fault flags, registered with them
module tmr_vote_monitor #(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inA,
  input  logic             inB,
  input  logic             inC,
  input  logic             clr,
  output logic             out,
  output logic             err,
  output logic [1:0]       errIdx,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB,
  output logic [CNT_W-1:0] cntC,
  output logic [2:0]       fault,
  output logic             faultAny
);

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } repStateT;

  localparam logic [7:0]       PERSIST_V = 8'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Two-out-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // One-hot mismatch vector to replica index; with 1-bit replicas at most
  // one bit can be set, anything else maps to "none".
  function automatic logic [1:0] encIdx(input logic [2:0] mm);
    case (mm)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic             majS;
  logic [2:0]       mmS;
  repStateT         stateR    [3];
  repStateT         stateNext [3];
  logic [7:0]       runR      [3];
  logic [7:0]       runNext   [3];
  logic [CNT_W-1:0] cntR      [3];
  logic [CNT_W-1:0] cntNext   [3];
  logic [2:0]       faultNext;

  assign majS = maj3(inA, inB, inC);
  assign mmS  = {inC ^ majS, inB ^ majS, inA ^ majS};

  // Next-state, run-length and counter logic for each replica's persistence FSM.
  always_comb begin
    faultNext = 3'b000;
    for (int k = 0; k < 3; k++) begin
      stateNext[k] = stateR[k];
      runNext[k]   = runR[k];
      cntNext[k]   = cntR[k];
      if (clr) begin
        // The mismatch of the clearing cycle is discarded entirely.
        stateNext[k] = OK;
        runNext[k]   = 8'd0;
        cntNext[k]   = {CNT_W{1'b0}};
      end else begin
        if (mmS[k] && (cntR[k] != CNT_MAX)) begin
          cntNext[k] = cntR[k] + CNT_ONE;
        end else begin
          cntNext[k] = cntR[k];
        end
        case (stateR[k])
          OK: begin
            if (mmS[k]) begin
              if (PERSIST_V == 8'd1) begin
                stateNext[k] = FAULT;
                runNext[k]   = 8'd0;
              end else begin
                stateNext[k] = SUSPECT;
                runNext[k]   = 8'd1;
              end
            end else begin
              stateNext[k] = OK;
              runNext[k]   = 8'd0;
            end
          end
          SUSPECT: begin
            if (mmS[k]) begin
              if ((runR[k] + 8'd1) == PERSIST_V) begin
                stateNext[k] = FAULT;
                runNext[k]   = 8'd0;
              end else begin
                stateNext[k] = SUSPECT;
                runNext[k]   = runR[k] + 8'd1;
              end
            end else begin
              // One clean cycle breaks the streak.
              stateNext[k] = OK;
              runNext[k]   = 8'd0;
            end
          end
          FAULT: begin
            stateNext[k] = FAULT;
            runNext[k]   = 8'd0;
          end
          default: begin
            stateNext[k] = OK;
            runNext[k]   = 8'd0;
          end
        endcase
      end
      // Flag tracks the FSM state it will hold after this edge.
      faultNext[k] = (stateNext[k] == FAULT);
    end
  end

  // Persistence FSM state and run-length registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        stateR[k] <= OK;
        runR[k]   <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        stateR[k] <= stateNext[k];
        runR[k]   <= runNext[k];
      end
    end
  end

  // Saturating mismatch counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        cntR[k] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        cntR[k] <= cntNext[k];
      end
    end
  end

  // Registered vote, error report and fault flags; clr leaves the vote path alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 1'b0;
      err      <= 1'b0;
      errIdx   <= 2'd0;
      fault    <= 3'b000;
      faultAny <= 1'b0;
    end else begin
      out      <= majS;
      err      <= |mmS;
      errIdx   <= encIdx(mmS);
      fault    <= faultNext;
      faultAny <= |faultNext;
    end
  end

  assign cntA = cntR[0];
  assign cntB = cntR[1];
  assign cntC = cntR[2];

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Downstream consumer of a triplicated FSM's replica outputs (outA/outB/outC of a TMR state machine).
- Each cycle it majority-votes the three replica bits into one registered output.
- Identifies which replica disagrees with the vote and keeps a saturating mismatch count per replica.
- Runs a per-replica persistence FSM that raises a sticky fault flag when one replica disagrees for PERSIST consecutive cycles, separating transient upsets from a stuck replica.

Parameters:
- CNT_W, 8, width of each per-replica mismatch counter; saturates at 2^CNT_W-1.
- PERSIST, 4, number of consecutive mismatch cycles of one replica that declares it faulty; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inA  input  1  replica A bit.
- inB  input  1  replica B bit.
- inC  input  1  replica C bit.
- clr  input  1  synchronous clear of counters, run lengths, FSMs and fault flags; does not affect out.
- out  output 1  registered majority of inA/inB/inC.
- err  output 1  registered; 1 if any replica disagreed with the majority in the sampled cycle.
- errIdx  output 2  registered; 0 = none, 1 = A, 2 = B, 3 = C disagreed.
- cntA  output CNT_W  saturating mismatch count for replica A.
- cntB  output CNT_W  saturating mismatch count for replica B.
- cntC  output CNT_W  saturating mismatch count for replica C.
- fault  output 3  sticky persistent-fault flags, bit0 = A, bit1 = B, bit2 = C.
- faultAny  output 1  OR of fault bits, registered alongside fault.

Behaviour:
- Clock and reset: one clock clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out=0, err=0, errIdx=0, cntA/B/C=0, fault=0, faultAny=0, all FSMs in OK, all run lengths 0. rst has priority over clr and over data.
- Vote: maj = (inA&inB)|(inB&inC)|(inA&inC).
  - With 1-bit replicas at most one replica can disagree.
  - mmA = inA^maj, mmB = inB^maj, mmC = inC^maj; at most one is set.
- Latency: out, err and errIdx reflect inputs sampled at edge N and are visible after edge N, i.e. 1 cycle.
- Counters: cntK increments by 1 on each mmK cycle and holds at all-ones (no wrap).
- Persistence FSM, one per replica K, with states OK, SUSPECT, FAULT and run length runK:
  - OK, mmK=1: if PERSIST==1, go to FAULT; otherwise go to SUSPECT with runK=1.
  - OK, mmK=0: stay in OK.
  - SUSPECT, mmK=1: runK+1; if runK+1==PERSIST, go to FAULT.
  - SUSPECT, mmK=0: go to OK with runK=0. A single clean cycle breaks the streak.
  - FAULT: absorbing; exited only by clr or rst. cntK keeps counting while in FAULT.
  - fault[K]=1 exactly when FSM K is in FAULT; it is set on the same edge as the transition into FAULT.
- clr:
  - On the edge where clr=1, counters, runs, FSMs (to OK), fault and faultAny are cleared.
  - The mismatch of that same cycle is discarded: not counted, not started as a streak.
  - out, err and errIdx still update normally in that cycle.
- Replica switch: if replica B mismatches while A is in SUSPECT, A returns to OK (mmA=0) and B goes to SUSPECT with runB=1.
- Input state: no X-propagation requirement; inputs are assumed already synchronous to clk.

Test Plan:
- Reset with inA=inB=inC=1 held: during rst out=0, all counters 0. First edge after rst release: out=1, err=0, errIdx=0.
- Single transient, PERSIST=4: inB=0 for 1 cycle, others 1.
  - Next cycle: err=1, errIdx=2, out=1.
  - cntB=1, fault=0, B FSM returns to OK one cycle later.
- Persistent fault, PERSIST=4: inC inverted for 4 consecutive cycles.
  - After the 4th edge: fault=3'b100, faultAny=1, cntC=4.
  - inC restored: fault stays 3'b100.
  - Pulse clr: fault=0, cntC=0.
- Broken streak: inA mismatches 3 cycles, 1 clean cycle, then 3 more mismatches.
  - Result: fault[0]=0, cntA=6.
- Saturation, CNT_W=3, PERSIST=255: inA stuck mismatched for 10 cycles.
  - cntA reaches 7 and holds at 7.
- clr collision: clr=1 in the same cycle as an inB mismatch with B in SUSPECT (runB=2).
  - Next cycle: cntB=0, B in OK, fault[1]=0.
  - err=1 and errIdx=2 still reported for that cycle.
